// File: rtl/note_player_pkg.sv
// ---------------------------------------------------------------------------
// note_player_pkg
//   Shared definitions for the note player: the FSM state type and its
//   fixed 3-bit encodings, used by the controller, the note sequencer and
//   the test bench.
// ---------------------------------------------------------------------------
package note_player_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_HIGH = 3'd1,
        ST_WAIT_HIGH = 3'd2,
        ST_LOAD_LOW  = 3'd3,
        ST_WAIT_LOW  = 3'd4
    } state_t;

endpackage : note_player_pkg

// File: rtl/note_player_down_counter.sv
// ---------------------------------------------------------------------------
// note_player_down_counter
//   Loadable down-counter with a zero flag. A load has priority over a
//   decrement. A decrement at zero is ignored, so the counter never wraps.
//
//   Ports:
//     clk        - clock, rising edge
//     rst        - synchronous active-high reset (value -> 0)
//     load       - load load_value on the next edge
//     load_value - value to load
//     dec        - decrement by one on the next edge (if nonzero)
//     value      - current count
//     zero       - high when value == 0
// ---------------------------------------------------------------------------
module note_player_down_counter #(
    parameter int p_nbits = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [p_nbits-1:0] load_value,
    input  logic               dec,
    output logic [p_nbits-1:0] value,
    output logic               zero
);

    assign zero = (value == '0);

    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (dec && !zero) begin
            value <= value - 1'b1;
        end
    end

endmodule : note_player_down_counter

// File: rtl/note_player_duty_ctrl.sv
// ---------------------------------------------------------------------------
// note_player_duty_ctrl
//   Square-wave note generator with independently programmable high and low
//   phase lengths, repeated for a programmed number of periods. A start /
//   stop / done handshake lets a sequencer chain notes back to back.
//
//   High phase = high_len + 2 cycles, low phase = low_len + 2 cycles,
//   busy time = dur * (high_len + low_len + 4) cycles.
//
//   Ports:
//     clk      - clock, rising edge
//     rst      - synchronous active-high reset
//     start    - begin a note (sampled in IDLE only)
//     stop     - abort the current note (honoured outside IDLE)
//     high_len - high phase parameter
//     low_len  - low phase parameter
//     dur      - number of full periods; 0 completes immediately
//     note     - square-wave output
//     busy     - high whenever not IDLE
//     done     - single-cycle completion pulse (combinational)
//     state    - current FSM state, for debug
// ---------------------------------------------------------------------------
module note_player_duty_ctrl
    import note_player_pkg::*;
#(
    parameter int p_len_nbits = 8,
    parameter int p_dur_nbits = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic [p_len_nbits-1:0] high_len,
    input  logic [p_len_nbits-1:0] low_len,
    input  logic [p_dur_nbits-1:0] dur,
    output logic                   note,
    output logic                   busy,
    output logic                   done,
    output logic [2:0]             state
);

    state_t state_q;
    state_t state_d;

    logic [p_len_nbits-1:0] hi_r;
    logic [p_len_nbits-1:0] lo_r;

    logic                   cnt_load;
    logic [p_len_nbits-1:0] cnt_load_value;
    logic                   cnt_dec;
    logic [p_len_nbits-1:0] cnt_value;
    logic                   cnt_zero;

    logic                   rem_load;
    logic                   rem_dec;
    logic [p_dur_nbits-1:0] rem_value;
    logic                   rem_zero;

    logic                   latch_ops;
    logic                   done_raw;

    // Phase down-counter: reloaded at the start of each phase.
    note_player_down_counter #(.p_nbits(p_len_nbits)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .dec        (cnt_dec),
        .value      (cnt_value),
        .zero       (cnt_zero)
    );

    // Periods-remaining counter: loaded with dur on an accepted start.
    note_player_down_counter #(.p_nbits(p_dur_nbits)) u_rem (
        .clk        (clk),
        .rst        (rst),
        .load       (rem_load),
        .load_value (dur),
        .dec        (rem_dec),
        .value      (rem_value),
        .zero       (rem_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hi_r    <= '0;
            lo_r    <= '0;
        end else begin
            state_q <= state_d;
            if (latch_ops) begin
                hi_r <= high_len;
                lo_r <= low_len;
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned -- that is what would infer a latch.
        state_d        = state_q;
        note           = 1'b0;
        busy           = 1'b0;
        done_raw       = 1'b0;
        latch_ops      = 1'b0;
        cnt_load       = 1'b0;
        cnt_load_value = '0;
        cnt_dec        = 1'b0;
        rem_load       = 1'b0;
        rem_dec        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (dur != '0) begin
                        latch_ops = 1'b1;
                        rem_load  = 1'b1;
                        state_d   = ST_LOAD_HIGH;
                    end else begin
                        // Zero-length note completes in the request cycle.
                        done_raw = 1'b1;
                    end
                end
            end
            ST_LOAD_HIGH: begin
                note           = 1'b1;
                busy           = 1'b1;
                cnt_load       = 1'b1;
                cnt_load_value = hi_r;
                state_d        = ST_WAIT_HIGH;
            end
            ST_WAIT_HIGH: begin
                note = 1'b1;
                busy = 1'b1;
                if (cnt_zero) state_d = ST_LOAD_LOW;
                else          cnt_dec = 1'b1;
            end
            ST_LOAD_LOW: begin
                busy           = 1'b1;
                cnt_load       = 1'b1;
                cnt_load_value = lo_r;
                state_d        = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                busy = 1'b1;
                if (cnt_zero) begin
                    if (rem_value == p_dur_nbits'(1) || rem_zero) begin
                        done_raw = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        rem_dec = 1'b1;
                        state_d = ST_LOAD_HIGH;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                // Illegal encodings: all outputs stay 0, recover to IDLE.
                state_d = ST_IDLE;
            end
        endcase

        // Abort outranks the normal transition and suppresses done.
        if (stop && state_q != ST_IDLE) begin
            state_d  = ST_IDLE;
            done_raw = 1'b0;
            cnt_load = 1'b0;
            cnt_dec  = 1'b0;
            rem_dec  = 1'b0;
        end
    end

    // Reset also masks the Mealy done path so outputs read their reset values.
    assign done  = done_raw && !rst;
    assign state = state_q;

endmodule : note_player_duty_ctrl

// File: tb/tb_note_player_duty_ctrl.sv
// ---------------------------------------------------------------------------
// tb_note_player_duty_ctrl
//   Directed self-checking bench for note_player_duty_ctrl.
// ---------------------------------------------------------------------------
module tb_note_player_duty_ctrl;
    import note_player_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [7:0]  high_len;
    logic [7:0]  low_len;
    logic [15:0] dur;
    logic        note;
    logic        busy;
    logic        done;
    logic [2:0]  state;

    int checks   = 0;
    int failures = 0;

    note_player_duty_ctrl #(.p_len_nbits(8), .p_dur_nbits(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .high_len (high_len),
        .low_len  (low_len),
        .dur      (dur),
        .note     (note),
        .busy     (busy),
        .done     (done),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Advance to the next cycle; inputs are then driven 1 time unit after
    // the edge and outputs checked 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a start request in an IDLE cycle and step past the edge.
    task automatic do_start(input int h, input int l, input int d);
        high_len = 8'(h);
        low_len  = 8'(l);
        dur      = 16'(d);
        start    = 1'b1;
        #1;
        check("start_idle_busy", 32'(busy), 32'd0);
        check("start_idle_done", 32'(done), (d == 0) ? 32'd1 : 32'd0);
        tick();
        start = 1'b0;
    endtask

    // Check every busy cycle of a note just accepted. With perturb set, the
    // operands are scrambled and start pulsed while playing. Returns in the
    // first IDLE cycle after done.
    task automatic expect_note(input int h, input int l, input int d,
                               input bit perturb);
        int period;
        int total;
        int p;
        period = h + l + 4;
        total  = d * period;
        for (int i = 0; i < total; i++) begin
            if (perturb) begin
                start    = i[0];
                high_len = 8'($urandom);
                low_len  = 8'($urandom);
                dur      = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            #1;
            p = i % period;
            check($sformatf("note_c%0d", i), 32'(note), (p < h + 2) ? 32'd1 : 32'd0);
            check($sformatf("busy_c%0d", i), 32'(busy), 32'd1);
            check($sformatf("done_c%0d", i), 32'(done), (i == total - 1) ? 32'd1 : 32'd0);
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b1;
        stop     = 1'b0;
        high_len = 8'd3;
        low_len  = 8'd3;
        dur      = 16'd0;

        // Reset held two cycles with start high: start must be ignored.
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_state", 32'(state), 32'd0);
            check("rst_note",  32'(note),  32'd0);
            check("rst_busy",  32'(busy),  32'd0);
            check("rst_done",  32'(done),  32'd0);
        end
        start = 1'b0;
        rst   = 1'b0;
        tick();
        check("post_rst_state", 32'(state), 32'd0);

        // Basic note: 1111 000 1111 000, busy 14 cycles, done in cycle 14.
        do_start(2, 1, 2);
        check("basic_first_state", 32'(state), 32'(ST_LOAD_HIGH));
        expect_note(2, 1, 2, 1'b0);
        #1;
        check("basic_end_busy",  32'(busy),  32'd0);
        check("basic_end_state", 32'(state), 32'd0);
        check("basic_end_done",  32'(done),  32'd0);
        tick();

        // dur = 0: done in the start cycle, never busy.
        do_start(4, 4, 0);
        #1;
        check("dur0_state", 32'(state), 32'd0);
        check("dur0_busy",  32'(busy),  32'd0);
        check("dur0_done",  32'(done),  32'd0);
        tick();

        // Zero lengths: 11 00 then done.
        do_start(0, 0, 1);
        expect_note(0, 0, 1, 1'b0);
        #1;
        check("zero_len_end_busy", 32'(busy), 32'd0);
        tick();

        // Stop in the 3rd WAIT_HIGH cycle (busy cycle 4) of a long note.
        do_start(5, 2, 3);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stop_pre_note_c%0d", i), 32'(note), 32'd1);
            tick();
        end
        stop = 1'b1;
        #1;
        check("stop_cycle_state", 32'(state), 32'(ST_WAIT_HIGH));
        check("stop_cycle_done",  32'(done),  32'd0);
        tick();
        stop = 1'b0;
        #1;
        check("stop_after_state", 32'(state), 32'd0);
        check("stop_after_note",  32'(note),  32'd0);
        check("stop_after_busy",  32'(busy),  32'd0);
        check("stop_after_done",  32'(done),  32'd0);
        tick();
        check("stop_stays_idle", 32'(state), 32'd0);

        // Busy immunity, then back-to-back start in the first IDLE cycle.
        do_start(3, 2, 2);
        expect_note(3, 2, 2, 1'b1);
        do_start(1, 0, 1);
        expect_note(1, 0, 1, 1'b0);
        #1;
        check("b2b_end_busy", 32'(busy), 32'd0);
        tick();

        // start and stop together in IDLE: start wins.
        stop = 1'b1;
        do_start(0, 1, 1);
        stop = 1'b0;
        check("start_stop_idle_state", 32'(state), 32'(ST_LOAD_HIGH));
        expect_note(0, 1, 1, 1'b0);

        // Reset mid-note.
        do_start(6, 6, 4);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_mid_state", 32'(state), 32'd0);
        check("rst_mid_note",  32'(note),  32'd0);
        check("rst_mid_busy",  32'(busy),  32'd0);
        check("rst_mid_done",  32'(done),  32'd0);
        tick();

        // Maximum lengths: 257 high cycles then 257 low cycles, no wrap.
        do_start(255, 255, 1);
        expect_note(255, 255, 1, 1'b0);
        #1;
        check("max_end_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_note_player_duty_ctrl
